// File: rtl/vec_norm_ctrl_pkg.sv
// Shared types and constants for the vector normaliser: Q8.7 sign-magnitude format,
// FSM state encoding and a combinational integer square root.
package vec_norm_ctrl_pkg;

    localparam int W    = 16;
    localparam int FRAC = 7;
    localparam logic [W-1:0] ONE     = 16'h0080;
    localparam logic [W-1:0] SAT_MAX = 16'h7FFF;

    typedef logic [3:0] state_t;

    // SQX..SCZ and DONE are consecutive so the FSM can step with +1.
    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_SQX  = 4'd1;
    localparam state_t ST_SQY  = 4'd2;
    localparam state_t ST_SQZ  = 4'd3;
    localparam state_t ST_ISQ  = 4'd4;
    localparam state_t ST_SCX  = 4'd5;
    localparam state_t ST_SCY  = 4'd6;
    localparam state_t ST_SCZ  = 4'd7;
    localparam state_t ST_DONE = 4'd8;

    function automatic logic [W-1:0] signed_out(input logic s, input logic [W-2:0] mag);
        return (mag == '0) ? '0 : {s, mag};
    endfunction

    function automatic logic [15:0] isqrt32(input logic [31:0] v);
        logic [31:0] rem;
        logic [31:0] res;
        logic [31:0] bit_v;
        rem = v;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            bit_v = 32'd1 << (2 * i);
            if (rem >= res + bit_v) begin
                rem = rem - (res + bit_v);
                res = (res >> 1) + bit_v;
            end else begin
                res = res >> 1;
            end
        end
        return res[15:0];
    endfunction

endpackage

// File: rtl/fp_as.sv
// Unsigned Q8.7 add/subtract: additions saturate at SAT_MAX, subtractions clamp at zero.
module fp_as
    import vec_norm_ctrl_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] s_o,
    output logic         ovf_o
);

    logic [W:0] sum;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = 1'b0;
        if (sub_i) begin
            s_o = (b_i > a_i) ? '0 : a_i - b_i;
        end else if (sum > {1'b0, SAT_MAX}) begin
            s_o   = SAT_MAX;
            ovf_o = 1'b1;
        end else begin
            s_o = sum[W-1:0];
        end
    end

endmodule

// File: rtl/fp_invsqrt.sv
// Combinational Q8.7 reciprocal square root: r = floor(sqrt(2^21 / a)); a zero input yields SAT_MAX.
module fp_invsqrt
    import vec_norm_ctrl_pkg::*;
(
    input  logic [W-1:0] a_i,
    output logic [W-1:0] r_o
);

    // 2^21 = ONE^3: the 1/sqrt of a Q8.7 value rescaled back into Q8.7.
    localparam logic [31:0] NUM = 32'(ONE) * 32'(ONE) * 32'(ONE);

    logic [31:0] q;

    always_comb begin
        q   = '0;
        r_o = SAT_MAX;
        if (a_i != '0) begin
            q   = NUM / 32'(a_i);
            r_o = isqrt32(q);
        end
    end

endmodule

// File: rtl/fp_mul.sv
// Q8.7 sign-magnitude multiplier; magnitude saturates to SAT_MAX and flags overflow.
module fp_mul
    import vec_norm_ctrl_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] p_o,
    output logic         ovf_o
);

    logic [31:0] prod;
    logic [31:0] scaled;

    always_comb begin
        prod   = 32'(a_i[W-2:0]) * 32'(b_i[W-2:0]);
        scaled = prod >> FRAC;
        ovf_o  = |scaled[31:W-1];
        p_o    = {a_i[W-1] ^ b_i[W-1], ovf_o ? SAT_MAX[W-2:0] : scaled[W-2:0]};
    end

endmodule

// File: rtl/vec_norm_ctrl.sv
// Sequential 3-component vector normaliser sharing one multiplier between the
// squaring and scaling phases; reciprocal square root settles during ISQ.
module vec_norm_ctrl
    import vec_norm_ctrl_pkg::*;
#(
    parameter int INVSQRT_WAIT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    input  logic [W-1:0] z_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x_out,
    output logic [W-1:0] y_out,
    output logic [W-1:0] z_out,
    output logic         ovf,
    output logic         zero_err,
    output state_t       state_o
);

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [W-1:0]   xl_q, xl_d, yl_q, yl_d, zl_q, zl_d;
    logic [W-1:0]   acc_q, acc_d, r_q, r_d;
    logic [W-1:0]   xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
    logic           ovf_q, ovf_d, zerr_q, zerr_d;

    logic [W-1:0]   comp;
    logic [W-1:0]   mul_a, mul_b, mul_p, as_s, isq_r, scaled_out;
    logic           mul_ovf, as_ovf;

    fp_mul u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(mul_p), .ovf_o(mul_ovf));
    fp_as u_as (.a_i(acc_q), .b_i(mul_p), .sub_i(1'b0), .s_o(as_s), .ovf_o(as_ovf));
    fp_invsqrt u_isq (.a_i(acc_q), .r_o(isq_r));

    // Operand selection depends only on registered state, never on start.
    always_comb begin
        case (state_q)
            ST_SQX, ST_SCX: comp = xl_q;
            ST_SQY, ST_SCY: comp = yl_q;
            ST_SQZ, ST_SCZ: comp = zl_q;
            default:        comp = '0;
        endcase
    end

    assign scaled_out = signed_out(comp[W-1], mul_p[W-2:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        zl_d    = zl_q;
        acc_d   = acc_q;
        r_d     = r_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        ovf_d   = ovf_q;
        zerr_d  = zerr_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    xl_d    = x_in;
                    yl_d    = y_in;
                    zl_d    = z_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    zerr_d  = 1'b0;
                    state_d = ST_SQX;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SQX, ST_SQY, ST_SQZ: begin
                mul_a   = {1'b0, comp[W-2:0]};
                mul_b   = {1'b0, comp[W-2:0]};
                acc_d   = as_s;
                ovf_d   = ovf_q | mul_ovf | as_ovf;
                state_d = state_t'(state_q + 4'd1);
            end
            ST_ISQ: begin
                if (acc_q == '0) begin
                    zerr_d  = 1'b1;
                    xo_d    = '0;
                    yo_d    = '0;
                    zo_d    = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == 3'(INVSQRT_WAIT - 1)) begin
                    r_d     = isq_r;
                    cnt_d   = '0;
                    state_d = ST_SCX;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_SCX, ST_SCY, ST_SCZ: begin
                mul_a   = {1'b0, comp[W-2:0]};
                mul_b   = r_q;
                ovf_d   = ovf_q | mul_ovf;
                state_d = state_t'(state_q + 4'd1);
                if (state_q == ST_SCX)      xo_d = scaled_out;
                else if (state_q == ST_SCY) yo_d = scaled_out;
                else                        zo_d = scaled_out;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            zl_q    <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
            ovf_q   <= 1'b0;
            zerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            zl_q    <= zl_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
            ovf_q   <= ovf_d;
            zerr_q  <= zerr_d;
        end
    end

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign x_out    = xo_q;
    assign y_out    = yo_q;
    assign z_out    = zo_q;
    assign ovf      = ovf_q;
    assign zero_err = zerr_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_vec_norm_ctrl.sv
// Directed bench for vec_norm_ctrl: latency, Q8.7 results, zero/overflow paths,
// back-to-back start, start-while-busy and mid-job reset.
module tb_vec_norm_ctrl;
    import vec_norm_ctrl_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic         busy, done, ovf, zero_err;
    logic [W-1:0] x_out, y_out, z_out;
    state_t       state_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    vec_norm_ctrl #(.INVSQRT_WAIT(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .ovf(ovf), .zero_err(zero_err), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tol > 0 compares magnitudes within tol LSB and requires matching sign bits.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp,
                         input int tol = 0);
        int  diff;
        bit  ok;
        total++;
        if (tol == 0) begin
            ok = (got === exp);
        end else begin
            diff = int'(got[14:0]) - int'(exp[14:0]);
            if (diff < 0) diff = -diff;
            ok = (got[15] === exp[15]) && (diff <= tol);
        end
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic start_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             input bit hold, output int t0);
        @(negedge clk);
        x_in  = x;
        y_in  = y;
        z_in  = z;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) start = 1'b0;
    endtask

    // Latency counts the cycle after the start edge as cycle 1; -1 means no done seen.
    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
    endtask

    initial begin
        int t0, lat, n_done;
        bit found;

        #3;
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_ovf", 16'(ovf), 16'h0);
        check("rst_zerr", 16'(zero_err), 16'h0);
        check("rst_x", x_out, 16'h0000);
        check("rst_y", y_out, 16'h0000);
        check("rst_z", z_out, 16'h0000);
        check("rst_state", 16'(state_o), 16'(ST_IDLE));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        start_job(16'h0080, 16'h0000, 16'h0000, 1'b0, t0);
        wait_done(t0, lat);
        check("unit_lat", 16'(lat), 16'd8);
        check("unit_x", x_out, 16'h0080, 2);
        check("unit_y", y_out, 16'h0000);
        check("unit_z", z_out, 16'h0000);
        check("unit_ovf", 16'(ovf), 16'h0);
        check("unit_zerr", 16'(zero_err), 16'h0);
        @(negedge clk);
        check("unit_done_pulse", 16'(done), 16'h0);
        check("unit_idle", 16'(state_o), 16'(ST_IDLE));
        check("unit_hold_x", x_out, 16'h0080, 2);

        start_job(16'h0180, 16'h0200, 16'h0000, 1'b0, t0);
        wait_done(t0, lat);
        check("v345_lat", 16'(lat), 16'd8);
        check("v345_x", x_out, 16'h004D, 3);
        check("v345_y", y_out, 16'h0066, 3);
        check("v345_z", z_out, 16'h0000);
        check("v345_ovf", 16'(ovf), 16'h0);

        start_job(16'h8180, 16'h0200, 16'h0000, 1'b0, t0);
        wait_done(t0, lat);
        check("sgn_x", x_out, 16'h804D, 3);
        check("sgn_y", y_out, 16'h0066, 3);
        check("sgn_z", z_out, 16'h0000);

        start_job(16'h0000, 16'h0000, 16'h0000, 1'b0, t0);
        wait_done(t0, lat);
        check("zero_lat", 16'(lat), 16'd5);
        check("zero_zerr", 16'(zero_err), 16'h1);
        check("zero_x", x_out, 16'h0000);
        check("zero_y", y_out, 16'h0000);
        check("zero_z", z_out, 16'h0000);
        check("zero_ovf", 16'(ovf), 16'h0);

        // 0x7F00 squared saturates to 0x7FFF, so r = 1/16 and x_out = 0x7F00 >> 4.
        start_job(16'h7F00, 16'h0000, 16'h0000, 1'b1, t0);
        x_in = 16'h0080;
        wait_done(t0, lat);
        check("ovf_lat", 16'(lat), 16'd8);
        check("ovf_flag", 16'(ovf), 16'h1);
        check("ovf_x", x_out, 16'h07F0, 2);
        check("ovf_zerr", 16'(zero_err), 16'h0);
        t0 = cyc + 1;
        @(negedge clk);
        check("b2b_state", 16'(state_o), 16'(ST_SQX));
        check("b2b_busy", 16'(busy), 16'h1);
        check("b2b_ovf_clr", 16'(ovf), 16'h0);
        start = 1'b0;
        wait_done(t0, lat);
        check("b2b_lat", 16'(lat), 16'd8);
        check("b2b_x", x_out, 16'h0080, 2);
        check("b2b_ovf", 16'(ovf), 16'h0);

        start_job(16'h0180, 16'h0200, 16'h0000, 1'b0, t0);
        repeat (2) @(negedge clk);
        x_in  = 16'h7F00;
        y_in  = 16'h7F00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(t0, lat);
        check("busy_ign_lat", 16'(lat), 16'd8);
        check("busy_ign_x", x_out, 16'h004D, 3);
        check("busy_ign_y", y_out, 16'h0066, 3);
        check("busy_ign_ovf", 16'(ovf), 16'h0);

        start_job(16'h0180, 16'h0200, 16'h0000, 1'b0, t0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state_o == ST_SCY) begin
                found = 1'b1;
                break;
            end
        end
        check("scy_reached", 16'(found), 16'h1);
        check("scy_x_pre", x_out, 16'h004D, 3);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_x", x_out, 16'h0000);
        check("mid_rst_state", 16'(state_o), 16'(ST_IDLE));
        check("mid_rst_busy", 16'(busy), 16'h0);
        check("mid_rst_done", 16'(done), 16'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("mid_rst_no_done", 16'(n_done), 16'd0);
        check("mid_rst_idle", 16'(state_o), 16'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
